// File: rtl/battle_city_rom_pkg.sv
// Shared constants and the in-flight tag type for the brick sprite ROM arbiter.
package battle_city_rom_pkg;

  localparam int unsigned ROM_ADDR_W = 11;
  localparam int unsigned ROM_DATA_W = 4;
  localparam int unsigned ROM_DEPTH  = 1296;
  localparam int unsigned SPRITE_DIM = 36;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic       oor;
  } rom_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx
);

  logic            found;
  logic [IdxW-1:0] pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IdxW'((32'(ptr) + k) % N);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        grant_idx  = pos;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/battle_city_rom_arbiter.sv
// Shares one brick sprite ROM between N_REQ requesters; one read per clock,
// responses routed back in acceptance order after ROM_LAT+1 cycles.
module battle_city_rom_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned ADDR_W    = battle_city_rom_pkg::ROM_ADDR_W,
  parameter int unsigned DATA_W    = battle_city_rom_pkg::ROM_DATA_W,
  parameter int unsigned ROM_DEPTH = battle_city_rom_pkg::ROM_DEPTH,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic                    vga_clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_oor,
  output logic                    busy
);

  import battle_city_rom_pkg::rom_tag_t;

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(ROM_DEPTH);

  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  grant;
  logic [IdxW-1:0]   grant_idx;
  logic              accept;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_oor;
  rom_tag_t          new_tag;
  rom_tag_t          tag_q [ROM_LAT+1];
  rom_tag_t          issue_tag, mature_tag;
  logic [DATA_W-1:0] rsp_data_q;

  rr_arbiter #(
    .N(N_REQ)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  always_comb begin
    req_ready = reset ? '0 : grant;
    accept    = |req_ready;
    gnt_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
    gnt_oor   = ({1'b0, gnt_addr} >= DepthW);
    rom_addr  = (accept && !gnt_oor) ? gnt_addr : '0;

    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == IdxW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    new_tag.valid = accept;
    new_tag.idx   = 3'(grant_idx);
    new_tag.oor   = accept & gnt_oor;
  end

  // issue_tag lines up with rom_q; mature_tag is the cycle the response is visible
  assign issue_tag  = tag_q[ROM_LAT-1];
  assign mature_tag = tag_q[ROM_LAT];

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      for (int unsigned k = 0; k <= ROM_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_q[0] <= new_tag;
      for (int unsigned k = 1; k <= ROM_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      if (issue_tag.valid) begin
        rsp_data_q <= issue_tag.oor ? '0 : rom_q;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = mature_tag.valid && (mature_tag.idx == 3'(i)) && !reset;
    end
    rsp_oor  = mature_tag.valid & mature_tag.oor & ~reset;
    rsp_data = reset ? '0 : rsp_data_q;
    busy     = 1'b0;
    for (int unsigned k = 0; k <= ROM_LAT; k++) begin
      busy = busy | tag_q[k].valid;
    end
  end

endmodule

// File: tb/tb_battle_city_rom_arbiter.sv
// Scoreboard bench: two arbiters (ROM_LAT 1 and 3) share stimulus, each with its own ROM model.
module tb_battle_city_rom_arbiter;

  localparam int unsigned NR   = 3;
  localparam int unsigned AW   = 11;
  localparam int unsigned DW   = 4;
  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  typedef struct {
    int unsigned   due;
    logic [NR-1:0] vld;
    logic [DW-1:0] data;
    logic          oor;
  } sb_t;

  logic             vga_clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;

  logic [NR-1:0] rdy_w   [2];
  logic [AW-1:0] raddr_w [2];
  logic [DW-1:0] rq_w    [2];
  logic [NR-1:0] rv_w    [2];
  logic [DW-1:0] rd_w    [2];
  logic          ro_w    [2];
  logic          busy_w  [2];

  logic [AW-1:0] sr0 = '0;
  logic [AW-1:0] sr1 [3] = '{default: '0};

  sb_t           sbq [2][$];
  logic [DW-1:0] last_data [2];
  int unsigned   cyc = 0;
  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  int unsigned   ptr_m = 0;

  battle_city_rom_arbiter #(
    .N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(1296), .ROM_LAT(LAT0)
  ) u_dut_lat1 (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(rdy_w[0]),
    .rom_addr (raddr_w[0]),
    .rom_q    (rq_w[0]),
    .rsp_valid(rv_w[0]),
    .rsp_data (rd_w[0]),
    .rsp_oor  (ro_w[0]),
    .busy     (busy_w[0])
  );

  battle_city_rom_arbiter #(
    .N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(1296), .ROM_LAT(LAT1)
  ) u_dut_lat3 (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(rdy_w[1]),
    .rom_addr (raddr_w[1]),
    .rom_q    (rq_w[1]),
    .rsp_valid(rv_w[1]),
    .rsp_data (rd_w[1]),
    .rsp_oor  (ro_w[1]),
    .busy     (busy_w[1])
  );

  always #5 vga_clk = ~vga_clk;

  // ROM contents: data = address[3:0], delivered LAT cycles after the address
  always @(posedge vga_clk) begin
    sr0    <= raddr_w[0];
    sr1[0] <= raddr_w[1];
    sr1[1] <= sr1[0];
    sr1[2] <= sr1[1];
    cyc    <= cyc + 1;
  end
  assign rq_w[0] = sr0[3:0];
  assign rq_w[1] = sr1[2][3:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int unsigned lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  logic [NR-1:0] exp_g;
  int unsigned   exp_i;
  logic          found;
  logic [AW-1:0] exp_addr;
  logic          exp_oor;
  sb_t           ent;

  always @(negedge vga_clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        check_eq("ready_in_reset", 32'(rdy_w[d]), 32'd0);
        check_eq("rsp_valid_in_reset", 32'(rv_w[d]), 32'd0);
        sbq[d].delete();
        last_data[d] = '0;
      end
      ptr_m = 0;
    end else begin
      exp_g = '0;
      exp_i = 0;
      found = 1'b0;
      for (int k = 0; k < int'(NR); k++) begin
        int unsigned j;
        j = (ptr_m + k) % NR;
        if (!found && req_valid[j]) begin
          exp_g[j] = 1'b1;
          exp_i    = j;
          found    = 1'b1;
        end
      end
      exp_addr = req_addr[exp_i*AW +: AW];
      exp_oor  = (exp_addr >= 11'd1296);

      for (int d = 0; d < 2; d++) begin
        check_eq("busy", 32'(busy_w[d]), 32'(sbq[d].size() != 0));
        if (sbq[d].size() != 0 && sbq[d][0].due == cyc) begin
          ent = sbq[d].pop_front();
          check_eq("rsp_valid", 32'(rv_w[d]), 32'(ent.vld));
          check_eq("rsp_data", 32'(rd_w[d]), 32'(ent.data));
          check_eq("rsp_oor", 32'(ro_w[d]), 32'(ent.oor));
          last_data[d] = ent.data;
        end else begin
          check_eq("rsp_idle_valid", 32'(rv_w[d]), 32'd0);
          check_eq("rsp_idle_hold", 32'(rd_w[d]), 32'(last_data[d]));
          check_eq("rsp_idle_oor", 32'(ro_w[d]), 32'd0);
        end
        check_eq("req_ready", 32'(rdy_w[d]), 32'(exp_g));
        check_eq("rom_addr", 32'(raddr_w[d]), (found && !exp_oor) ? 32'(exp_addr) : 32'd0);
        if (found) begin
          ent.due  = cyc + lat_of(d) + 1;
          ent.vld  = exp_g;
          ent.data = exp_oor ? 4'h0 : exp_addr[3:0];
          ent.oor  = exp_oor;
          sbq[d].push_back(ent);
        end
      end
      if (found) ptr_m = (exp_i + 1) % NR;
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2, input int n);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    drive(3'b000, 11'd0, 11'd0, 11'd0, n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(1296, 2047));
    return AW'($urandom_range(0, 1295));
  endfunction

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    repeat (2) tick();
    reset = 1'b0;

    // single requester
    drive(3'b010, 11'd0, 11'd37, 11'd0, 1);
    idle(6);

    // full contention from rr_ptr=0
    do_reset();
    drive(3'b111, 11'd10, 11'd20, 11'd30, 6);
    idle(6);

    // fairness wrap: rr_ptr=1 with requesters 0 and 2 active
    do_reset();
    drive(3'b001, 11'd5, 11'd0, 11'd0, 1);
    idle(1);
    drive(3'b101, 11'd7, 11'd0, 11'd9, 3);
    idle(6);

    // out-of-range boundary
    do_reset();
    drive(3'b001, 11'd1296, 11'd0, 11'd0, 1);
    drive(3'b001, 11'd1295, 11'd0, 11'd0, 1);
    drive(3'b100, 11'd0, 11'd0, 11'd2047, 1);
    idle(6);

    // reset with reads in flight
    do_reset();
    drive(3'b001, 11'd3, 11'd0, 11'd0, 1);
    drive(3'b010, 11'd0, 11'd6, 11'd0, 1);
    do_reset();
    idle(3);
    drive(3'b111, 11'd1, 11'd2, 11'd3, 1);
    idle(6);

    // random traffic with one mid-stream reset
    for (int n = 0; n < 300; n++) begin
      if (n == 150) do_reset();
      drive(NR'($urandom_range(0, 7)), rand_addr(), rand_addr(), rand_addr(), 1);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
